mdu: RTL

Iterative multiply/divide unit, the parametrised successor to the single-cycle ALU: covers the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at any WIDTH, one bit per cycle. Sits beside the ALU in the execute stage. Operands enter and results leave through valid/ready handshakes, so the controller stalls while an operation is in flight. Exposes the same `zero` flag semantics as the ALU.

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/mdu_negate.sv | 13 +
 rtl/mdu.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 op codes,
// FSM states and the iteration-counter width helper.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negator, used for operand magnitudes and the
// final sign fix-up.
module mdu_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             en_i,
  input  logic [WIDTH-1:0] val_i,
  output logic [WIDTH-1:0] val_o
);

  assign val_o = en_i ? ('0 - val_i) : val_i;

endmodule

// File: rtl/mdu.sv
// Iterative RV32M-style multiply/divide unit: one bit per cycle, valid/ready
// on both sides, registered result with a zero flag.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int unsigned    CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e             state_q;
  op_e                op_q;
  logic               neg_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   result_q;
  logic               in_ready_q;
  logic               out_valid_q;

  op_e                op_in;
  logic               a_neg, b_neg, res_neg;
  logic               is_div, is_rem, div0, ovf;
  logic [WIDTH-1:0]   a_mag, b_mag, special_res;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] acc_d, fix_in, fix_out;
  logic [WIDTH-1:0]   res_d;

  mdu_negate #(.WIDTH(WIDTH)) u_neg_a (.en_i(a_neg), .val_i(a), .val_o(a_mag));
  mdu_negate #(.WIDTH(WIDTH)) u_neg_b (.en_i(b_neg), .val_i(b), .val_o(b_mag));

  always_comb begin
    op_in   = op_e'(op);
    is_div  = op[2];
    is_rem  = op[2] & op[1];
    a_neg   = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) & a[WIDTH-1];
    b_neg   = (op_in inside {OP_MULH, OP_DIV, OP_REM}) & b[WIDTH-1];
    // Remainder follows the dividend; product and quotient follow sign(a)^sign(b).
    res_neg = is_rem ? a_neg : (a_neg ^ b_neg);
    div0    = is_div && (b == '0);
    ovf     = (op_in inside {OP_DIV, OP_REM}) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    if (div0) special_res = is_rem ? a : '1;
    else      special_res = is_rem ? '0 : a;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (op_q[2]) begin
      if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                  acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
    // Divide results are zero-extended so one wide negator serves both paths.
    if (op_q[2]) fix_in = {{WIDTH{1'b0}}, (op_q[1] ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0])};
    else         fix_in = acc_d;
  end

  mdu_negate #(.WIDTH(2*WIDTH)) u_neg_res (.en_i(neg_q), .val_i(fix_in), .val_o(fix_out));

  always_comb begin
    if (!op_q[2] && (op_q[1:0] != 2'b00)) res_d = fix_out[2*WIDTH-1:WIDTH];
    else                                  res_d = fix_out[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_MUL;
      neg_q       <= 1'b0;
      opnd_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q       <= op_in;
            neg_q      <= res_neg;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            if (div0 || ovf) begin
              result_q    <= special_res;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              opnd_q  <= is_div ? b_mag : a_mag;
              acc_q   <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          if (cnt_q == LAST) begin
            cnt_q       <= '0;
            result_q    <= res_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = (result_q == '0);

endmodule
